// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets (word
// index taken from address[3:2]), FSM state encodings, source indices and a
// helper that packs the CUR status word.
package irq_pkg;

    localparam int NSRC_DEFAULT = 3;

    // Source indices into irq_src / MASK / PEND
    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

    // Register map, address[3:2]
    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_CUR  = 2'd2;
    localparam logic [1:0] REG_EOI  = 2'd3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // CUR register: {29'b0, active, id[1:0]}
    function automatic logic [31:0] cur_word(input logic active, input logic [1:0] id);
        return {29'b0, active, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: selects the lowest set bit of an NSRC-bit vector.
// Ports:
//   vec   - candidate vector (pending & enabled)
//   valid - at least one bit of vec is set
//   idx   - index of the lowest set bit (0 when vec is all zero)
module irq_prio_enc #(
    parameter int NSRC = 3
) (
    input  logic [NSRC-1:0] vec,
    output logic            valid,
    output logic [1:0]      idx
);

    always_comb begin
        valid = |vec;
        idx   = 2'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for two timers and one external pin. Rising edges on
// irq_src set PEND bits; the lowest enabled pending source is presented to
// the CPU as irq_req/irq_id, acknowledged by irq_ack and closed by a write
// to EOI. No nesting: while a handler is in service, new edges only pend.
//
// Ports:
//   clk      - rising-edge system clock
//   reset    - asynchronous active-low reset
//   address  - word address [31:2]; only [3:2] decoded
//   WE       - register write strobe
//   dataIn   - write data
//   dataOut  - combinational read data of the selected register
//   irq_src  - level interrupt lines (0 = TC0, 1 = TC1, 2 = external)
//   irq_req  - interrupt request to the CPU (registered, state decode)
//   irq_id   - latched index of the requested / in-service source
//   irq_ack  - single-cycle CPU acknowledge (handler entry)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; latch lowest PEND&MASK and go REQ
// ST_REQ     | irq_req high, id frozen; ack -> SERVICE, withdrawn -> IDLE
// ST_SERVICE | handler running, CUR.active = 1; EOI write -> IDLE
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     address,
    input  logic            WE,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_req,
    output logic [1:0]      irq_id,
    input  logic            irq_ack
);

    logic [1:0]      state_q, state_d;
    logic [NSRC-1:0] mask_q,  mask_d;
    logic [NSRC-1:0] pend_q,  pend_d;
    logic [NSRC-1:0] src_q,   src_d;
    logic [1:0]      id_q,    id_d;

    logic [NSRC-1:0] src_rise;
    logic [NSRC-1:0] pend_en;
    logic            sel_valid;
    logic [1:0]      sel_idx;
    logic            id_live;
    logic            wr_mask, wr_pend, wr_eoi;

    // Address bits above [3:2] and write-data bits above the source field
    // carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{address[31:4], dataIn[31:NSRC]};

    assign wr_mask = WE && (address[3:2] == REG_MASK);
    assign wr_pend = WE && (address[3:2] == REG_PEND);
    assign wr_eoi  = WE && (address[3:2] == REG_EOI);

    assign src_rise = irq_src & ~src_q;
    assign pend_en  = pend_q & mask_q;
    assign id_live  = pend_en[id_q];

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio (
        .vec   (pend_en),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        src_d   = irq_src;
        mask_d  = wr_mask ? dataIn[NSRC-1:0] : mask_q;

        // Software clear first, then edge set so a same-cycle edge wins.
        pend_d  = pend_q;
        if (wr_pend) begin
            pend_d = pend_d & ~dataIn[NSRC-1:0];
        end
        pend_d  = pend_d | src_rise;

        state_d = state_q;
        id_d    = id_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    id_d    = sel_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    // Acknowledge clear overrides any edge set of the same bit.
                    pend_d[id_q] = 1'b0;
                    state_d      = ST_SERVICE;
                end else if (!id_live) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            src_q   <= '0;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            src_q   <= src_d;
            id_q    <= id_d;
        end
    end

    assign irq_req = (state_q == ST_REQ);
    assign irq_id  = id_q;

    always_comb begin
        dataOut = 32'b0;
        case (address[3:2])
            REG_MASK: dataOut[NSRC-1:0] = mask_q;
            REG_PEND: dataOut[NSRC-1:0] = pend_q;
            REG_CUR:  dataOut = cur_word(state_q == ST_SERVICE, id_q);
            default:  dataOut = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic. Each
// applied vector pushes the expected outputs from a behavioural model into a
// queue; a monitor on the falling edge pops and compares.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] address = '0;
    logic        WE = 1'b0;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;
    logic [2:0]  irq_src = '0;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic        irq_ack = 1'b0;

    irq_ctrl #(.NSRC(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .WE      (WE),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        req;
        bit [1:0]  id;
        bit [31:0] rd;
        int        tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;
    bit   stim_done = 1'b0;

    // Behavioural model: what software would observe.
    localparam int M_IDLE = 0;
    localparam int M_WAIT_ACK = 1;
    localparam int M_HANDLER = 2;
    bit [2:0] m_pend, m_mask, m_prev;
    int       m_mode;
    int       m_id;

    function automatic int lowest(input bit [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [31:0] m_read(input bit [1:0] a);
        case (a)
            2'd0: return {29'b0, m_mask};
            2'd1: return {29'b0, m_pend};
            2'd2: return (m_mode == M_HANDLER) ? (32'd4 + 32'(m_id)) : 32'(m_id);
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_clear();
        m_pend = '0; m_mask = '0; m_prev = '0; m_mode = M_IDLE; m_id = 0;
    endtask

    // Effect of one clock edge given the inputs held during the cycle.
    task automatic m_edge(input bit we, input bit [1:0] a, input bit [31:0] d,
                          input bit [2:0] s, input bit ack);
        bit [2:0] np;
        bit [2:0] live;
        np = m_pend;
        if (we && a == 2'd1) np = np & ~d[2:0];
        np = np | (s & ~m_prev);
        live = m_pend & m_mask;
        if (m_mode == M_IDLE) begin
            if (live != 0) begin
                m_id = lowest(live);
                m_mode = M_WAIT_ACK;
            end
        end else if (m_mode == M_WAIT_ACK) begin
            if (ack) begin
                np[m_id] = 1'b0;
                m_mode = M_HANDLER;
            end else if (!live[m_id]) begin
                m_mode = M_IDLE;
            end
        end else begin
            if (we && a == 2'd3) m_mode = M_IDLE;
        end
        if (we && a == 2'd0) m_mask = d[2:0];
        m_pend = np;
        m_prev = s;
    endtask

    task automatic apply(input bit rn, input bit we, input bit [1:0] a,
                         input bit [31:0] d, input bit [2:0] s, input bit ack);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rn;
        WE      = we;
        address = {28'($urandom), a};
        dataIn  = d;
        irq_src = s;
        irq_ack = ack;
        if (!rn) m_clear();
        e.req = (m_mode == M_WAIT_ACK);
        e.id  = 2'(m_id);
        e.rd  = m_read(a);
        e.tag = n_push;
        n_push++;
        exp_q.push_back(e);
        if (rn) m_edge(we, a, d, s, ack);
    endtask

    task automatic idle(input int n, input bit [2:0] s, input bit [1:0] a);
        for (int k = 0; k < n; k++) apply(1, 0, a, 32'd0, s, 0);
    endtask

    task automatic wait_req(input bit [2:0] s, input string name);
        int k;
        for (k = 0; k < 40 && m_mode != M_WAIT_ACK; k++) apply(1, 0, 2'd1, 0, s, 0);
        if (m_mode != M_WAIT_ACK) begin
            n_err++;
            $display("FAIL %s: no request within 40 cycles", name);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (irq_req !== e.req || irq_id !== e.id || dataOut !== e.rd) begin
                    n_err++;
                    $display("FAIL vec%0d addr=%0d: irq_req=%b exp %b, irq_id=%0d exp %0d, dataOut=%h exp %h",
                             e.tag, address[3:2], irq_req, e.req, irq_id, e.id, dataOut, e.rd);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit [2:0] s;
        bit [1:0] a;
        bit       we;
        m_clear();
        apply(0, 0, 2'd0, 0, 0, 0);
        apply(0, 0, 2'd2, 0, 0, 0);
        apply(1, 0, 2'd1, 0, 0, 0);

        // Single TC1 pulse, all enabled: pend, request id 1, ack, CUR = 5.
        apply(1, 1, 2'd0, 32'h7, 3'b000, 0);
        apply(1, 0, 2'd1, 0, 3'b010, 0);
        apply(1, 0, 2'd1, 0, 3'b000, 0);
        apply(1, 0, 2'd2, 0, 3'b000, 0);
        apply(1, 0, 2'd1, 0, 3'b000, 1);
        apply(1, 0, 2'd2, 0, 3'b000, 0);
        apply(1, 1, 2'd2, 32'hFFFF_FFFF, 3'b000, 0);
        apply(1, 1, 2'd3, 0, 3'b000, 0);
        idle(2, 3'b000, 2'd2);

        // Two sources at once: id 1 first, then id 2 after ack + EOI.
        apply(1, 0, 2'd1, 0, 3'b110, 0);
        idle(2, 3'b000, 2'd1);
        apply(1, 0, 2'd2, 0, 3'b000, 1);
        apply(1, 0, 2'd1, 0, 3'b000, 0);
        apply(1, 1, 2'd3, 0, 3'b000, 0);
        idle(2, 3'b000, 2'd2);
        apply(1, 0, 2'd2, 0, 3'b000, 1);
        apply(1, 1, 2'd3, 0, 3'b000, 0);
        idle(2, 3'b000, 2'd1);

        // Masked source pends without a request; enabling it raises one.
        apply(1, 1, 2'd0, 32'h0, 3'b000, 0);
        apply(1, 0, 2'd1, 0, 3'b001, 0);
        idle(3, 3'b000, 2'd1);
        apply(1, 1, 2'd0, 32'h1, 3'b000, 0);
        idle(3, 3'b000, 2'd2);

        // Software clear while requesting withdraws the request.
        apply(1, 1, 2'd1, 32'h1, 3'b000, 0);
        idle(3, 3'b000, 2'd2);

        // Edge during service only pends; EOI then lets it through.
        apply(1, 1, 2'd0, 32'h7, 3'b001, 0);
        wait_req(3'b000, "req_tc0");
        apply(1, 0, 2'd2, 0, 3'b000, 1);
        apply(1, 0, 2'd1, 0, 3'b100, 0);
        idle(3, 3'b100, 2'd1);
        apply(1, 1, 2'd3, 0, 3'b100, 0);
        idle(3, 3'b100, 2'd2);
        apply(1, 0, 2'd2, 0, 3'b100, 1);
        apply(1, 1, 2'd3, 0, 3'b000, 0);

        // Ack and edge on the same bit in one cycle; ack clear wins.
        apply(1, 0, 2'd1, 0, 3'b001, 0);
        wait_req(3'b000, "req_ack_edge");
        apply(1, 0, 2'd1, 0, 3'b001, 1);
        apply(1, 1, 2'd1, 32'h1, 3'b000, 0);
        apply(1, 1, 2'd3, 0, 3'b001, 0);
        idle(3, 3'b000, 2'd1);
        apply(1, 1, 2'd1, 32'h7, 3'b000, 0);
        idle(2, 3'b000, 2'd2);

        // Held level gives one interrupt; reset mid-request clears all.
        for (int k = 0; k < 10; k++) begin
            apply(1, (k == 6), (k == 6) ? 2'd3 : 2'd2, 0, 3'b001, (k == 3));
        end
        idle(3, 3'b001, 2'd1);
        apply(1, 0, 2'd1, 0, 3'b000, 0);
        apply(1, 0, 2'd1, 0, 3'b001, 0);
        wait_req(3'b001, "req_before_reset");
        apply(0, 0, 2'd1, 0, 3'b001, 0);
        apply(0, 0, 2'd0, 0, 3'b001, 0);
        apply(1, 0, 2'd1, 0, 3'b001, 0);
        idle(4, 3'b001, 2'd1);
        apply(1, 1, 2'd0, 32'h7, 3'b001, 0);
        idle(3, 3'b001, 2'd2);

        // Randomized traffic
        s = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) s = s ^ 3'($urandom);
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom);
            apply(($urandom_range(0, 199) != 0), we, a, $urandom, s,
                  ($urandom_range(0, 2) == 0));
        end
        apply(1, 0, 2'd0, 0, s, 0);

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
